// File: rtl/csr_regbank.sv
// Byte-enabled CSR bank: NREGS data registers, a W1C STATUS register with a sticky
// error bit, an IRQ enable register, registered read port and registered interrupt.
module csr_regbank #(
    parameter int unsigned NREGS     = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned RD_OFFSET = 256,
    localparam int unsigned AW       = $clog2(NREGS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_we,
    input  logic [AW-1:0]       csr_addr,
    input  logic [DW-1:0]       csr_wdata,
    input  logic [DW/8-1:0]     csr_be,
    input  logic                csr_re,
    output logic [DW-1:0]       csr_rdata,
    output logic                csr_rvalid,
    input  logic [NREGS-1:0]    hw_set,
    output logic [NREGS*DW-1:0] regs_out,
    output logic                irq
);

    localparam int unsigned   NB          = DW / 8;
    localparam logic [AW-1:0] ADDR_STATUS = AW'(NREGS);
    localparam logic [AW-1:0] ADDR_IRQEN  = AW'(NREGS + 1);

    logic [NREGS-1:0][DW-1:0] data_q, data_d;
    logic [DW-1:0]            status_q, status_d;
    logic [NREGS-1:0]         irq_en_q, irq_en_d;
    logic [DW-1:0]            rdata_q, rdata_d;
    logic                     rvalid_q;
    logic                     irq_q, irq_d;

    logic [DW-1:0]            be_mask;
    logic [DW-1:0]            irq_en_merged;
    logic [DW-1:0]            status_clr;
    logic [DW-1:0]            status_set;
    logic [DW-1:0]            rd_val;
    logic                     wr_err;

    // Expand byte enables into a bit mask.
    always_comb begin
        be_mask = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            be_mask[b*8 +: 8] = {8{csr_be[b]}};
        end
    end

    assign wr_err        = csr_we && (csr_addr > ADDR_IRQEN);
    assign irq_en_merged = (DW'(irq_en_q) & ~be_mask) | (csr_wdata & be_mask);

    // Register next-state: byte-masked writes, W1C status where set beats clear.
    always_comb begin
        data_d     = data_q;
        irq_en_d   = irq_en_q;
        status_clr = '0;
        status_set = '0;

        for (int unsigned i = 0; i < NREGS; i++) begin
            if (csr_we && (csr_addr == AW'(i))) begin
                data_d[i] = (data_q[i] & ~be_mask) | (csr_wdata & be_mask);
            end
        end

        if (csr_we && (csr_addr == ADDR_IRQEN)) begin
            irq_en_d = irq_en_merged[NREGS-1:0];
        end

        if (csr_we && (csr_addr == ADDR_STATUS)) begin
            status_clr = csr_wdata & be_mask;
        end
        status_set[NREGS-1:0] = hw_set;
        status_set[DW-1]      = wr_err;
        status_d              = (status_q & ~status_clr) | status_set;

        irq_d = |(status_d[NREGS-1:0] & irq_en_d);
    end

    // Read mux over pre-write state; register 0 reads back with an offset.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (csr_addr == AW'(i)) begin
                rd_val = data_q[i];
            end
        end
        if (csr_addr == '0) begin
            rd_val = data_q[0] + DW'(RD_OFFSET);
        end
        if (csr_addr == ADDR_STATUS) begin
            rd_val = status_q;
        end
        if (csr_addr == ADDR_IRQEN) begin
            rd_val = DW'(irq_en_q);
        end
        rdata_d = csr_re ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            status_q <= '0;
            irq_en_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            rvalid_q <= csr_re;
            irq_q    <= irq_d;
        end
    end

    assign csr_rdata  = rdata_q;
    assign csr_rvalid = rvalid_q;
    assign irq        = irq_q;
    assign regs_out   = data_q;

endmodule
